// File: rtl/telemetry_pkg.sv
// Shared types and sizing helpers for the telemetry framer and related byte-stream blocks.
package telemetry_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tlm_state_t;

   localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
   localparam int         IDX_W        = 6;

   function automatic int bytes_per_ch(input int width);
      return (width + 7) / 8;
   endfunction

   function automatic int frame_len(input int num_ch, input int width, input int use_cksum);
      return 2 + num_ch * bytes_per_ch(width) + use_cksum;
   endfunction

endpackage

// File: rtl/tlm_checksum.sv
// Mod-256 byte accumulator; o_neg is the value that brings the running sum back to zero.
module tlm_checksum (
   input  logic       Clk,
   input  logic       debounced_reset,
   input  logic       i_clr,
   input  logic       i_add,
   input  logic [7:0] i_data,
   output logic [7:0] o_neg
);

   logic [7:0] sum;

   always_ff @(posedge Clk or negedge debounced_reset) begin
      if (!debounced_reset) begin
         sum <= 8'h00;
      end else if (i_clr) begin
         sum <= 8'h00;
      end else if (i_add) begin
         sum <= sum + i_data;
      end
   end

   assign o_neg = ~sum + 8'h01;

endmodule

// File: rtl/telemetry_framer.sv
// Snapshots NUM_CH channels per sample tick and streams SYNC, seq, LE payload and checksum
// to the UART, stalling on FIFO full and flagging ticks that arrive mid-frame.
//  state   | meaning
//  ST_IDLE | waiting for an enabled sample tick
//  ST_SEND | streaming byte idx of the snapshot frame
module telemetry_framer
   import telemetry_pkg::*;
#(
   parameter int         NUM_CH       = 2,
   parameter int         CH_WIDTH     = 16,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
   parameter int         USE_CHECKSUM = 1
) (
   input  logic                       Clk,
   input  logic                       debounced_reset,
   input  logic                       i_enable,
   input  logic                       i_sample_tick,
   input  logic [NUM_CH*CH_WIDTH-1:0] i_data,
   input  logic                       i_uart_full,
   input  logic                       i_clr_overrun,
   output logic                       o_uart_wr,
   output logic [7:0]                 o_uart_data,
   output logic                       o_busy,
   output logic                       o_overrun,
   output logic [7:0]                 o_seq
);

   localparam int BPC       = bytes_per_ch(CH_WIDTH);
   localparam int NPAY      = NUM_CH * BPC;
   localparam int DATA_W    = NUM_CH * CH_WIDTH;
   localparam int FRAME_LEN = frame_len(NUM_CH, CH_WIDTH, USE_CHECKSUM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   tlm_state_t         state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   pay_off;
   logic [DATA_W-1:0]  snap;
   logic [NPAY*8-1:0]  padded;
   logic [7:0]         pay_byte;
   logic [7:0]         byte_mux;
   logic [7:0]         cksum;
   logic               start;
   logic               last_wr;
   logic               frame_start;
   logic               is_ck_byte;
   logic               add_en;

   assign start       = i_sample_tick && i_enable;
   assign o_busy      = (state == ST_SEND);
   assign o_uart_wr   = o_busy && !i_uart_full;
   assign last_wr     = o_uart_wr && (idx == LAST_IDX);
   assign frame_start = start && ((state == ST_IDLE) || last_wr);
   assign is_ck_byte  = (USE_CHECKSUM != 0) && (idx == LAST_IDX);
   assign add_en      = o_uart_wr && (idx != '0) && !is_ck_byte;
   assign pay_off     = idx - IDX_W'(2);

   // Each channel occupies a whole number of bytes; bits above CH_WIDTH stay zero.
   always_comb begin
      padded = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         padded[ch*BPC*8 +: CH_WIDTH] = snap[ch*CH_WIDTH +: CH_WIDTH];
      end
   end

   always_comb begin
      pay_byte = 8'h00;
      for (int p = 0; p < NPAY; p++) begin
         if (pay_off == IDX_W'(p)) pay_byte = padded[p*8 +: 8];
      end
   end

   always_comb begin
      if (idx == '0)                    byte_mux = SYNC_BYTE;
      else if (idx == IDX_W'(1))        byte_mux = o_seq;
      else if (is_ck_byte)              byte_mux = cksum;
      else                              byte_mux = pay_byte;
   end

   assign o_uart_data = o_busy ? byte_mux : 8'h00;

   tlm_checksum u_cksum (
      .Clk             (Clk),
      .debounced_reset (debounced_reset),
      .i_clr           (frame_start),
      .i_add           (add_en),
      .i_data          (byte_mux),
      .o_neg           (cksum)
   );

   always_ff @(posedge Clk or negedge debounced_reset) begin
      if (!debounced_reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         snap      <= '0;
         o_seq     <= 8'h00;
         o_overrun <= 1'b0;
      end else begin
         // A tick landing on the last written byte chains the next frame instead of overrunning.
         if (start && (state == ST_SEND) && !last_wr) o_overrun <= 1'b1;
         else if (i_clr_overrun)                       o_overrun <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap  <= i_data;
                  idx   <= '0;
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (o_uart_wr) begin
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     o_seq <= o_seq + 8'h01;
                     if (start) snap  <= i_data;
                     else       state <= ST_IDLE;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_telemetry_framer.sv
// Randomised scoreboard bench for telemetry_framer: default build plus a 3x12-bit no-checksum build.
module tb_telemetry_framer;

   localparam int L1 = 7;
   localparam int L2 = 8;

   logic        Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        debounced_reset;
   logic        i_enable, i_sample_tick, i_uart_full, i_clr_overrun;
   logic [31:0] i_data;
   logic        o_uart_wr, o_busy, o_overrun;
   logic [7:0]  o_uart_data, o_seq;

   logic        tick2;
   logic [35:0] data2;
   logic        wr2, busy2, ovr2;
   logic [7:0]  udata2, seq2;

   telemetry_framer dut (
      .Clk (Clk), .debounced_reset (debounced_reset), .i_enable (i_enable),
      .i_sample_tick (i_sample_tick), .i_data (i_data), .i_uart_full (i_uart_full),
      .i_clr_overrun (i_clr_overrun), .o_uart_wr (o_uart_wr), .o_uart_data (o_uart_data),
      .o_busy (o_busy), .o_overrun (o_overrun), .o_seq (o_seq)
   );

   telemetry_framer #(.NUM_CH(3), .CH_WIDTH(12), .USE_CHECKSUM(0)) dut2 (
      .Clk (Clk), .debounced_reset (debounced_reset), .i_enable (1'b1),
      .i_sample_tick (tick2), .i_data (data2), .i_uart_full (1'b0),
      .i_clr_overrun (1'b0), .o_uart_wr (wr2), .o_uart_data (udata2),
      .o_busy (busy2), .o_overrun (ovr2), .o_seq (seq2)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   int         rem = 0, acc_cnt = 0, done_cnt = 0, acc2 = 0;
   logic       exp_ovr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame built from the byte-layout rules with plain arithmetic.
   function automatic logic [7:0] pay_byte(input int w, input logic [255:0] d, input int p);
      int bpc = (w + 7) / 8;
      logic [255:0] v;
      v = (d >> ((p / bpc) * w)) & ((256'd1 << w) - 256'd1);
      return v[8*(p % bpc) +: 8];
   endfunction

   function automatic logic [7:0] exp_byte(input int nch, input int w, input logic [255:0] d,
                                           input int seq, input int k);
      int npay = nch * ((w + 7) / 8);
      int s;
      if (k == 0) return 8'hA5;
      if (k == 1) return seq[7:0];
      if (k < 2 + npay) return pay_byte(w, d, k - 2);
      s = seq % 256;
      for (int j = 0; j < npay; j++) s += pay_byte(w, d, j);
      return 8'(256 - (s % 256));
   endfunction

   always @(negedge Clk) begin
      if (debounced_reset && o_uart_wr) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_byte: got %0h expected no write", o_uart_data);
         end else check("byte", {24'd0, o_uart_data}, {24'd0, q1.pop_front()});
      end
   end

   always @(negedge Clk) begin
      if (debounced_reset && wr2) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_byte2: got %0h expected no write", udata2);
         end else check("byte2", {24'd0, udata2}, {24'd0, q2.pop_front()});
      end
   end

   // One clock of stimulus on the default build, entered and left at posedge+1.
   task automatic step(input logic tick, input logic en, input logic full, input logic clr,
                       input logic [31:0] d);
      logic written, last, accepted, ovr_set;
      i_sample_tick = tick; i_enable = en; i_uart_full = full; i_clr_overrun = clr; i_data = d;
      written  = (rem > 0) && !full;
      last     = written && (rem == 1);
      accepted = tick && en && ((rem == 0) || last);
      ovr_set  = tick && en && !accepted;
      if (accepted) begin
         for (int k = 0; k < L1; k++) q1.push_back(exp_byte(2, 16, {224'd0, d}, acc_cnt % 256, k));
         acc_cnt++;
      end
      @(negedge Clk);
      check("wr", {31'd0, o_uart_wr}, {31'd0, written});
      check("busy", {31'd0, o_busy}, {31'd0, rem > 0});
      @(posedge Clk);
      #1;
      if (written)  rem--;
      if (last)     done_cnt++;
      if (accepted) rem = L1;
      if (ovr_set)  exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      i_sample_tick = 1'b0; i_clr_overrun = 1'b0;
      check("overrun", {31'd0, o_overrun}, {31'd0, exp_ovr});
      check("seq", {24'd0, o_seq}, done_cnt % 256);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && rem > 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
      check("drain_done", rem, 0);
   endtask

   task automatic reset_mid_frame();
      check("pre_reset_busy", {31'd0, o_busy}, 1);
      #1 debounced_reset = 1'b0;
      #1;
      check("rst_wr", {31'd0, o_uart_wr}, 0);
      check("rst_seq", {24'd0, o_seq}, 0);
      check("rst_busy", {31'd0, o_busy}, 0);
      check("rst_data", {24'd0, o_uart_data}, 0);
      check("rst_ovr", {31'd0, o_overrun}, 0);
      q1.delete(); q2.delete();
      rem = 0; acc_cnt = 0; done_cnt = 0; exp_ovr = 1'b0; acc2 = 0;
      @(negedge Clk) debounced_reset = 1'b1;
      @(posedge Clk) #1;
   endtask

   task automatic frame2(input logic [35:0] d);
      tick2 = 1'b1; data2 = d;
      for (int k = 0; k < L2; k++) q2.push_back(exp_byte(3, 12, {220'd0, d}, acc2 % 256, k));
      acc2++;
      @(posedge Clk) #1;
      tick2 = 1'b0; data2 = $urandom;
      repeat (L2 + 1) @(posedge Clk);
      #1;
      check("seq2", {24'd0, seq2}, acc2 % 256);
      check("q2_empty", q2.size(), 0);
   endtask

   initial begin
      logic [31:0] d1;
      d1 = {16'h00C8, 16'h1234};
      debounced_reset = 1'b0;
      i_enable = 1'b1; i_sample_tick = 1'b0; i_uart_full = 1'b0; i_clr_overrun = 1'b0;
      i_data = 32'h0; tick2 = 1'b0; data2 = 36'h0;
      #2;
      check("init_wr", {31'd0, o_uart_wr}, 0);
      check("init_data", {24'd0, o_uart_data}, 0);
      check("init_seq", {24'd0, o_seq}, 0);
      check("init_busy", {31'd0, o_busy}, 0);
      check("init_ovr", {31'd0, o_overrun}, 0);
      check("init_wr2", {31'd0, wr2}, 0);
      @(negedge Clk) debounced_reset = 1'b1;
      @(posedge Clk) #1;

      // plain frame, then the same with a 3-cycle stall after the third byte
      step(1'b1, 1'b1, 1'b0, 1'b0, d1);
      drain();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, d1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      drain();

      // overrun mid-frame, disabled tick ignored, then clear
      step(1'b1, 1'b1, 1'b0, 1'b0, d1);
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      drain();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

      // tick on the last-byte cycle chains a frame with new data
      step(1'b1, 1'b1, 1'b0, 1'b0, d1);
      for (int i = 0; i < 20 && rem != 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, {16'h0001, 16'hFFFF});
      drain();

      // long random run: back-to-back frames, stalls, overruns, clears, seq wrap
      for (int i = 0; i < 6000 && done_cnt < 300; i++) begin
         logic en, tk;
         en = ($urandom_range(0, 9) != 0);
         tk = (rem <= 1) ? 1'b1 : ($urandom_range(0, 19) == 0);
         step(tk, en, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom);
      end
      check("wrap_reached", {31'd0, done_cnt >= 300}, 1);
      drain();

      // reset mid-frame, then a clean frame from seq 0
      step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      reset_mid_frame();
      step(1'b1, 1'b1, 1'b0, 1'b0, d1);
      drain();

      // 3 x 12-bit, no checksum
      frame2({12'h123, 12'h456, 12'hABC});
      frame2(36'($urandom));
      frame2({4'($urandom), 32'($urandom)});

      check("q1_empty", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
